// File: rtl/syn_fifo_ex.sv
// syn_fifo_ex: single-clock sample FIFO with exact full/empty, fill level,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a selectable first-word-fall-through read mode.
module syn_fifo_ex #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int FWFT       = 0,
  parameter int AF_THR     = (1 << ADDR_WIDTH) - 4,
  parameter int AE_THR     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_THR);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_THR);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags are pure decodes of the registered level, so no wr/rd path reaches them.
  assign empty        = (level == '0);
  assign full         = (level == DEPTH_L);
  assign almost_empty = (level <= AE_L);
  assign almost_full  = (level >= AF_L);

  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;

  // Storage array; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst)
      mem[wr_ptr] <= data_in;
  end

  // Pointers advance only on accepted operations and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Level counter: one wider than the pointers so a full FIFO is distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full)   overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
      if (rd && empty)  underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; rd acknowledges it.
      assign data_out = mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      // Registered read port: loads the head word on an accepted read, else holds.
      always_ff @(posedge clk) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: doc/syn_fifo_ex.md
# syn_fifo_ex

Parametrised synchronous single-clock FIFO and next-generation replacement for the plain sample FIFO in the synth datapath. It holds audio samples and control words between producer and consumer stages. Over the plain FIFO it adds:
- a true depth of 2^ADDR_WIDTH, with full reachable;
- a fill-level output;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a selectable first-word-fall-through (FWFT) read mode.

## Interface
- DATA_WIDTH, 16, word width in bits
- ADDR_WIDTH, 6, log2 of depth; DEPTH = 2^ADDR_WIDTH words
- FWFT, 0, 0 = registered read data; 1 = head word presented without a read request
- AF_THR, DEPTH-4, almost_full asserts when level >= AF_THR; legal range 1..DEPTH
- AE_THR, 4, almost_empty asserts when level <= AE_THR; legal range 0..DEPTH-1

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd  in  1  read request
- data_out  out  DATA_WIDTH  read data
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- almost_empty  out  1  level <= AE_THR
- almost_full  out  1  level >= AF_THR
- level  out  ADDR_WIDTH+1  number of stored words, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow and underflow

## Operation
- Storage is a DEPTH x DATA_WIDTH RAM, with wr_ptr and rd_ptr each ADDR_WIDTH bits.
- Pointers wrap naturally from DEPTH-1 to 0.
- Level is a separate counter ADDR_WIDTH+1 bits wide, so full is exact.
- Write acceptance: wr_acc = wr && !full, using the flags registered before the edge.
- Read acceptance: rd_acc = rd && !empty, using the flags registered before the edge.
- On wr_acc: mem[wr_ptr] <= data_in and wr_ptr increments.
- On rd_acc: rd_ptr increments.
- Level update:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged when both or neither are accepted.
- Simultaneous wr and rd:
  - When neither full nor empty, both are accepted and level is unchanged.
  - When full, only the read is accepted, the write is dropped and overflow is set; level becomes DEPTH-1.
  - When empty, only the write is accepted, the read is dropped and underflow is set; level becomes 1.
- Error flags:
  - overflow sets on wr && full; underflow sets on rd && empty.
  - clr_err clears both flags at the next edge.
  - If a set condition and clr_err occur in the same cycle, set wins.
- Dropped operations never alter memory, pointers or level.
- All flags (empty, full, almost_*) are combinational decodes of the registered level. They therefore reflect an operation one cycle after its edge.
- Read modes:
  - FWFT=0: data_out is registered. It loads mem[rd_ptr] on rd_acc and holds its value otherwise.
  - FWFT=1: data_out = mem[rd_ptr] through an asynchronous RAM read. It is valid whenever empty=0 and undefined-but-stable when empty=1. rd acts as an acknowledge of the presented word.
- Reset (rst=1 at an edge):
  - wr_ptr, rd_ptr and level are cleared to 0;
  - empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0;
  - data_out=0 when FWFT=0.
- RAM contents are not cleared by reset.
- Reset dominates wr, rd and clr_err in the same cycle. Reset mid-stream discards all stored words.

## Timing
- Write to empty flag: wr_acc at edge N gives empty=0 after edge N, i.e. visible in cycle N+1.
- Read latency, FWFT=0: rd_acc at edge N gives the word on data_out after edge N.
- Read latency, FWFT=1: a word written at edge N is on data_out during cycle N+1. After rd_acc at edge M, the next word is shown during cycle M+1.
- Throughput is one write and one read per cycle, sustained indefinitely with level constant.
- No combinational path from wr or rd to any output. The only exception is none: the flags depend only on level.

## Test plan
- Reset, then write 1..DEPTH (DEPTH=64):
  - level steps 1..64;
  - almost_full rises at level 60;
  - full=1 after the 64th write;
  - a 65th write sets overflow, and level stays 64.
- From full, read 64 words in FWFT=0:
  - data_out sequence is 1..64, each one cycle after its rd;
  - almost_empty rises at level 4 and empty=1 at the end;
  - an extra rd sets underflow, and data_out holds 64.
- FWFT=1, write 0xA5A5 into the empty FIFO:
  - data_out=0xA5A5 with empty=0 the next cycle, with no rd;
  - rd then gives empty=1.
- Simultaneous wr and rd:
  - at level 10 for 200 cycles: level stays 10 and output order is preserved across pointer wrap;
  - when full with wr+rd: level becomes 63 and overflow=1;
  - when empty with wr+rd: level becomes 1 and underflow=1.
- Error flags and reset:
  - clr_err clears both flags;
  - clr_err together with an overflowing wr leaves overflow=1.
- Reset at level 37: level=0, empty=1, flags=0 and data_out=0 the next cycle; a subsequent write/read returns the new data only.
